key_sequence_checker: RTL and testbench
=======================================

# key_sequence_checker

Player-side counterpart of the sequence display path. After the game FSM has shown a round's sequence on the LEDs, it starts this block. The block then reads the player's synchronized key presses, encodes each one-hot press into a 2-bit symbol, and compares it against the expected symbol fetched by index from sequence storage. It reports a single pass/fail result per round, and the game FSM uses that result to advance the round or go to the lost state.

## Interface
- Reset: one clock; reset is asynchronous and active-high.
- Parameters:
  - `MAX_LEN`, 100: sequence storage depth; longest checkable round.
  - `IDX_W`, 8: width of index and length buses.
  - `TIMEOUT_CYCLES`, 50_000_000: per-symbol response window, in `clk` cycles.
- Ports:
  - `clk` in 1: system clock.
  - `rst` in 1: asynchronous active-high reset.
  - `start` in 1: begin checking a round; sampled only in IDLE.
  - `round_len` in IDX_W: number of symbols to check; sampled on `start`.
  - `keys` in 4: synchronized keys, active high; bit n maps to symbol n.
  - `exp_idx` out IDX_W: index of the expected symbol; registered.
  - `exp_sym` in 2: storage entry at `exp_idx`; combinational, valid in the same cycle.
  - `key_leds` out 4: echo of the key being pressed.
  - `busy` out 1: high in every state except IDLE.
  - `done` out 1: one-cycle pulse marking the round result.
  - `pass` out 1: result; valid while `done` is high.
  - `timed_out` out 1: fail cause was timeout; valid with `done`.

## Operation
- States: IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE:
  - On `start`: latch `len = min(round_len, MAX_LEN)` and set `exp_idx` to 0.
  - If `len == 0`, go to DONE with `pass = 1`; otherwise go to ARM.
- ARM: wait until `keys == 0`, then go to WAIT_PRESS. This drops the key still held from the start press.
- WAIT_PRESS: a press is any cycle with `keys != 0`.
  - Press is one-hot and its symbol equals `exp_sym`: go to WAIT_RELEASE.
  - Press is not one-hot (two or more keys): mismatch; go to DONE with `pass = 0`.
  - Press is one-hot but its symbol differs: go to DONE with `pass = 0`.
- WAIT_RELEASE:
  - On `keys == 0`: if `exp_idx == len-1`, go to DONE with `pass = 1`; else increment `exp_idx` and go to WAIT_PRESS.
  - Extra keys pressed while held are ignored.
- DONE: `done = 1` for exactly one cycle, then go to IDLE. `pass` and `timed_out` hold until the next `start`.
- `start` outside IDLE is ignored. There is no abort; `rst` is the only way to cancel a round.
- Symbol encoding: 0001→0, 0010→1, 0100→2, 1000→3.
- `exp_idx` never exceeds `len-1` and never wraps.

## Timing
- Reset values:
  - State: IDLE.
  - `exp_idx`: 0.
  - `key_leds`, `busy`, `done`, `pass`, `timed_out`: all 0.
- `start` sampled at edge N: `busy` is high from N+1.
- `len == 0`: `done` rises at N+1 and `busy` falls at N+2.
- Press decision uses the `keys` and `exp_sym` values sampled at one edge; the state changes at that same edge.
- `exp_idx` updates on the release edge, so `exp_sym` is settled before the next press can be sampled.
- `key_leds` is `keys` registered (one-cycle lag) in WAIT_PRESS and WAIT_RELEASE, and 0 in every other state.
- Last release at edge M: `done` and `pass` are high at M+1, and the block is in IDLE at M+2.
- `rst` mid-round forces every output to its reset value immediately; no `done` is produced.

## Configuration
- `KEY_TIMEOUT_EN` defined:
  - A down-counter loads `TIMEOUT_CYCLES-1` on entry to WAIT_PRESS.
  - It decrements each cycle while in WAIT_PRESS.
  - On reaching 0 with no press, the block goes to DONE with `pass = 0`, `timed_out = 1`.
  - A press in the same cycle as expiry takes priority over the timeout.
  - ARM and WAIT_RELEASE are never timed.
- `KEY_TIMEOUT_EN` undefined: the counter is not built, WAIT_PRESS waits indefinitely, and `timed_out` is tied to 0.

## Structure
- Package `sequence_pkg` holds:
  - `sym_t` (logic [1:0]).
  - Checker state enum `chk_state_t`.
  - Function `onehot_to_sym`, returning symbol plus a valid flag.
  - Default `MAX_LEN`.
- The display path uses the same `sym_t` and encoding from this package.
- Sub-module `response_timer` holds the load/decrement/expire counter. It is instantiated only under `KEY_TIMEOUT_EN`.

## Test plan
- Correct round: `round_len = 3`, storage {2,0,3}, presses 0100, 0001, 1000 each followed by release → one `done` pulse with `pass = 1`; `exp_idx` steps 0,1,2.
- Wrong symbol: `round_len = 2`, storage {1,1}, press 0010 then 0100 → `done` with `pass = 0` on the edge after the second press; `exp_idx = 1`.
- Held start key and multi-key: `keys = 0001` held through `start` → stays in ARM; after release, press 0011 → `pass = 0`.
- Empty round and clamp: `round_len = 0` → `done` with `pass = 1` one cycle after `start`. `round_len = 200` → `len` latched as 100.
- Timeout (`KEY_TIMEOUT_EN`, `TIMEOUT_CYCLES = 16`): no press → `done`, `pass = 0`, `timed_out = 1` 16 cycles after WAIT_PRESS entry. Press in the expiry cycle → press is accepted.
- Reset mid-round: assert `rst` in WAIT_RELEASE at `exp_idx = 2` → all outputs 0, state IDLE, no `done`. A following `start` behaves normally.

Source files
------------

// File: rtl/sequence_pkg.sv
// Shared symbol type, checker state encoding and one-hot key decode for the
// sequence display and checking paths.
package sequence_pkg;

  localparam int MAX_LEN_DEFAULT = 100;

  typedef logic [1:0] sym_t;

  typedef enum logic [2:0] {
    CHK_IDLE         = 3'd0,
    CHK_ARM          = 3'd1,
    CHK_WAIT_PRESS   = 3'd2,
    CHK_WAIT_RELEASE = 3'd3,
    CHK_DONE         = 3'd4
  } chk_state_t;

  typedef struct packed {
    logic valid;
    sym_t sym;
  } sym_dec_t;

  // valid is low for no key or for more than one key held at once.
  function automatic sym_dec_t onehot_to_sym(input logic [3:0] keys);
    sym_dec_t dec;
    dec.valid = 1'b1;
    dec.sym   = 2'd0;
    case (keys)
      4'b0001: dec.sym = 2'd0;
      4'b0010: dec.sym = 2'd1;
      4'b0100: dec.sym = 2'd2;
      4'b1000: dec.sym = 2'd3;
      default: dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/response_timer.sv
// Per-symbol response window: loads CYCLES-1, counts down while run is high,
// and flags expiry when the count sits at zero.
module response_timer #(
  parameter int CYCLES = 16,
  parameter int W      = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES - 1);
    end else if (run && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/key_sequence_checker.sv
// Checks the player's key presses against the stored round sequence and
// reports one pass/fail per round. KEY_TIMEOUT_EN adds a per-symbol timeout.
//   state        | meaning
//   IDLE         | waiting for start
//   ARM          | waiting for all keys released
//   WAIT_PRESS   | waiting for the next press
//   WAIT_RELEASE | correct key held, waiting for release
//   DONE         | one-cycle result pulse
module key_sequence_checker
  import sequence_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int IDX_W          = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] round_len,
  input  logic [3:0]       keys,
  output logic [IDX_W-1:0] exp_idx,
  input  logic [1:0]       exp_sym,
  output logic [3:0]       key_leds,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out
);

  localparam logic [IDX_W-1:0] MAX_LEN_W = IDX_W'(MAX_LEN);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  chk_state_t       state, state_nxt;
  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] len_clamped;
  sym_dec_t         dec;
  logic             any_key;
  logic             match;
  logic             last;
  logic             timeout_hit;

  assign len_clamped = (round_len > MAX_LEN_W) ? MAX_LEN_W : round_len;
  assign dec         = onehot_to_sym(keys);
  assign any_key     = |keys;
  assign match       = dec.valid && (dec.sym == sym_t'(exp_sym));
  assign last        = (exp_idx == len - IDX_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      CHK_IDLE:
        if (start) state_nxt = (len_clamped == '0) ? CHK_DONE : CHK_ARM;
      CHK_ARM:
        if (!any_key) state_nxt = CHK_WAIT_PRESS;
      CHK_WAIT_PRESS:
        // A press in the expiry cycle wins over the timeout.
        if (any_key)          state_nxt = match ? CHK_WAIT_RELEASE : CHK_DONE;
        else if (timeout_hit) state_nxt = CHK_DONE;
      CHK_WAIT_RELEASE:
        if (!any_key) state_nxt = last ? CHK_DONE : CHK_WAIT_PRESS;
      CHK_DONE:
        state_nxt = CHK_IDLE;
      default:
        state_nxt = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CHK_IDLE;
      len      <= '0;
      exp_idx  <= '0;
      pass     <= 1'b0;
      key_leds <= 4'b0;
    end else begin
      state <= state_nxt;
      key_leds <= (state_nxt == CHK_WAIT_PRESS || state_nxt == CHK_WAIT_RELEASE)
                  ? keys : 4'b0;
      if (state == CHK_IDLE && start) begin
        len     <= len_clamped;
        exp_idx <= '0;
        pass    <= (len_clamped == '0);
      end else if (state == CHK_WAIT_RELEASE && !any_key) begin
        if (last) pass    <= 1'b1;
        else      exp_idx <= exp_idx + IDX_W'(1);
      end
    end
  end

  assign busy = (state != CHK_IDLE);
  assign done = (state == CHK_DONE);

`ifdef KEY_TIMEOUT_EN
  logic timer_load;
  logic timer_run;
  logic expired;

  assign timer_load = (state != CHK_WAIT_PRESS) && (state_nxt == CHK_WAIT_PRESS);
  assign timer_run  = (state == CHK_WAIT_PRESS);

  response_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .run     (timer_run),
    .expired (expired)
  );

  assign timeout_hit = timer_run && expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out <= 1'b0;
    end else if (state == CHK_IDLE && start) begin
      timed_out <= 1'b0;
    end else if (state == CHK_WAIT_PRESS && !any_key && timeout_hit) begin
      timed_out <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_key_sequence_checker.sv
// Directed bench for key_sequence_checker: expected round results are queued
// by the stimulus and compared by a monitor whenever done pulses.
module tb_key_sequence_checker;

  typedef struct {
    logic p;
    logic t;
    int   idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] round_len;
  logic [3:0] keys;
  logic [7:0] exp_idx;
  logic [1:0] exp_sym;
  logic [3:0] key_leds;
  logic       busy, done, pass, timed_out;

  logic [1:0] mem [0:255];
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  assign exp_sym = mem[exp_idx];

  always #5 clk = ~clk;

  key_sequence_checker #(
    .MAX_LEN        (100),
    .IDX_W          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .round_len (round_len),
    .keys      (keys),
    .exp_idx   (exp_idx),
    .exp_sym   (exp_sym),
    .key_leds  (key_leds),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timed_out (timed_out)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_round(input int l);
    round_len = 8'(l);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    keys = k;
    step(1);
    keys = 4'b0;
    step(1);
  endtask

  task automatic expect_result(input logic p, input logic t, input int idx);
    exp_t e;
    e.p = p;
    e.t = t;
    e.idx = idx;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result_pass", pass, e.p);
        check("result_timed_out", timed_out, e.t);
        check("result_exp_idx", exp_idx, e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 2'd0;
    rst = 1'b1; start = 1'b0; keys = 4'b0; round_len = 8'd0;
    step(2);
    check("rst_exp_idx", exp_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_key_leds", key_leds, 0);
    rst = 1'b0;
    step(1);

    // Correct round {2,0,3}
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    begin_round(3);
    check("t1_busy_after_start", busy, 1);
    check("t1_idx0", exp_idx, 0);
    step(1);
    keys = 4'b0100;
    step(1);
    check("t1_key_leds", key_leds, 4'b0100);
    keys = 4'b0;
    step(1);
    check("t1_idx1", exp_idx, 1);
    press(4'b0001);
    check("t1_idx2", exp_idx, 2);
    expect_result(1'b1, 1'b0, 2);
    press(4'b1000);
    check("t1_done", done, 1);
    check("t1_key_leds_done", key_leds, 0);
    step(1);
    check("t1_done_one_cycle", done, 0);
    check("t1_idle", busy, 0);

    // Wrong symbol on second press
    mem[0] = 2'd1; mem[1] = 2'd1;
    begin_round(2);
    step(1);
    press(4'b0010);
    check("t2_idx1", exp_idx, 1);
    expect_result(1'b0, 1'b0, 1);
    keys = 4'b0100;
    step(1);
    check("t2_done", done, 1);
    keys = 4'b0;
    step(1);
    check("t2_idle", busy, 0);

    // Start key held, then multi-key press
    keys = 4'b0001;
    begin_round(2);
    step(5);
    check("t3_arm_busy", busy, 1);
    check("t3_arm_no_done", done, 0);
    keys = 4'b0;
    step(1);
    expect_result(1'b0, 1'b0, 0);
    keys = 4'b0011;
    step(1);
    check("t3_done", done, 1);
    keys = 4'b0;
    step(1);

    // Empty round
    expect_result(1'b1, 1'b0, 0);
    begin_round(0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 1);
    step(1);
    check("t4_idle", busy, 0);

    // Clamp 200 -> 100
    for (int i = 0; i < 100; i++) mem[i] = 2'(i % 4);
    begin_round(200);
    step(1);
    for (int i = 0; i < 99; i++) press(4'b0001 << mem[i]);
    check("t5_idx99", exp_idx, 99);
    expect_result(1'b1, 1'b0, 99);
    press(4'b0001 << mem[99]);
    check("t5_done_at_100", done, 1);
    step(1);

`ifdef KEY_TIMEOUT_EN
    mem[0] = 2'd1; mem[1] = 2'd2;
    begin_round(2);
    step(1);
    expect_result(1'b0, 1'b1, 0);
    step(15);
    check("t6_no_early_timeout", done, 0);
    step(1);
    check("t6_timeout_done", done, 1);
    check("t6_timed_out", timed_out, 1);
    step(1);
    check("t6_idle", busy, 0);

    begin_round(2);
    step(1);
    step(15);
    keys = 4'b0010;
    step(1);
    check("t7_press_wins", busy, 1);
    check("t7_no_done", done, 0);
    keys = 4'b0;
    step(1);
    expect_result(1'b1, 1'b0, 1);
    press(4'b0100);
    check("t7_done", done, 1);
    step(1);
`else
    mem[0] = 2'd2;
    begin_round(1);
    step(1);
    step(40);
    check("t6_no_timeout_busy", busy, 1);
    check("t6_no_timeout_done", done, 0);
    expect_result(1'b1, 1'b0, 0);
    press(4'b0100);
    check("t6_done", done, 1);
    step(1);
`endif

    // Reset mid-round in WAIT_RELEASE at index 2
    mem[0] = 2'd3; mem[1] = 2'd2; mem[2] = 2'd1; mem[3] = 2'd0;
    begin_round(4);
    step(1);
    press(4'b1000);
    press(4'b0100);
    check("t8_idx2", exp_idx, 2);
    keys = 4'b0010;
    step(1);
    check("t8_held_leds", key_leds, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("t8_rst_idx", exp_idx, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_done", done, 0);
    check("t8_rst_pass", pass, 0);
    check("t8_rst_key_leds", key_leds, 0);
    check("t8_rst_timed_out", timed_out, 0);
    step(2);
    keys = 4'b0;
    rst = 1'b0;
    step(1);
    check("t8_idle_after_rst", busy, 0);
    expect_result(1'b1, 1'b0, 0);
    begin_round(1);
    step(1);
    press(4'b1000);
    check("t8_done_after_rst", done, 1);
    step(2);

    check("pending_results", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
